// File: rtl/asrm_uart_tx_arbiter_pkg.sv
// rtl/asrm_uart_tx_arbiter_pkg.sv - shared state encodings and defaults for the UART TX arbiter
package asrm_uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_START    = 2'd1,
      ST_WAIT_END = 2'd2,
      ST_RELEASE  = 2'd3
   } arb_state_e;

   localparam int unsigned WDOG_MAX_DEFAULT = 32'd1200000;

endpackage

// File: rtl/asrm_rr_pick.sv
// rtl/asrm_rr_pick.sv - combinational round-robin selector: first set request at or after ptr
module asrm_rr_pick
   import asrm_uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  idx,
   output logic             found
);

   logic [ID_W:0] cand;

   // One extra bit keeps ptr+k exact so the wrap works for non-power-of-2 N_REQ.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_REQ)) begin
            cand = cand - (ID_W+1)'(N_REQ);
         end
         if (!found && req[cand[ID_W-1:0]]) begin
            found = 1'b1;
            idx   = cand[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/asrm_uart_tx_arbiter.sv
// rtl/asrm_uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between N_REQ byte producers
module asrm_uart_tx_arbiter
   import asrm_uart_tx_arbiter_pkg::*;
#(
   parameter int          N_REQ    = 4,
   parameter int          ID_W     = 2,
   parameter int unsigned WDOG_MAX = WDOG_MAX_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           uart_data_tx,
   output logic                 uart_start_transmit,
   input  logic                 uart_end_transmit,
   output logic                 busy,
   output logic [ID_W-1:0]      grant_id,
   output logic                 wdog_err
);

   localparam logic [31:0] WDOG_LAST = (WDOG_MAX == 0) ? 32'd0 : 32'(WDOG_MAX - 1);

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]  ready_q, ready_d;
   logic [7:0]        data_q, data_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              wdog_err_q, wdog_err_d;
   logic              end_prev_q, end_prev_d;
   logic [31:0]       wdog_cnt_q, wdog_cnt_d;

   logic [ID_W-1:0]   pick_idx;
   logic              pick_found;

   asrm_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      ready_d    = '0;
      data_d     = data_q;
      start_d    = start_q;
      busy_d     = busy_q;
      wdog_err_d = 1'b0;
      wdog_cnt_d = wdog_cnt_q;
      // Sampled every cycle, so prev already equals the line level on entry to WAIT_END.
      end_prev_d = uart_end_transmit;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               ready_d  = N_REQ'(1) << pick_idx;
               data_d   = req_data[int'(pick_idx)*8 +: 8];
               grant_d  = pick_idx;
               busy_d   = 1'b1;
               rr_ptr_d = (pick_idx == ID_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            start_d    = 1'b1;
            wdog_cnt_d = '0;
            state_d    = ST_WAIT_END;
         end
         ST_WAIT_END: begin
            // Start must drop on the end edge or the core resends at its stop-bit tick.
            if (uart_end_transmit && !end_prev_q) begin
               start_d = 1'b0;
               state_d = ST_RELEASE;
            end else if (WDOG_MAX != 0 && wdog_cnt_q == WDOG_LAST) begin
               start_d    = 1'b0;
               wdog_err_d = 1'b1;
               state_d    = ST_RELEASE;
            end else begin
               wdog_cnt_d = wdog_cnt_q + 32'd1;
            end
         end
         ST_RELEASE: begin
            if (!uart_end_transmit) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         ready_q    <= '0;
         data_q     <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         wdog_err_q <= 1'b0;
         end_prev_q <= 1'b0;
         wdog_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         ready_q    <= ready_d;
         data_q     <= data_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         wdog_err_q <= wdog_err_d;
         end_prev_q <= end_prev_d;
         wdog_cnt_q <= wdog_cnt_d;
      end
   end

   assign req_ready           = ready_q;
   assign uart_data_tx        = data_q;
   assign uart_start_transmit = start_q;
   assign busy                = busy_q;
   assign grant_id            = grant_q;
   assign wdog_err            = wdog_err_q;

endmodule

// File: tb/tb_asrm_uart_tx_arbiter.sv
// tb/tb_asrm_uart_tx_arbiter.sv - scoreboard bench for the UART TX arbiter with a behavioural UART core stand-in
module tb_asrm_uart_tx_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  uart_data_tx;
   logic        uart_start_transmit;
   logic        uart_end_transmit;
   logic        busy;
   logic [1:0]  grant_id;
   logic        wdog_err;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] src_q[4][$];
   logic [3:0] extra_v;
   logic       hang;
   int         n_chk, n_pass;
   int         start_rises, wdog_total, ready1_cnt;
   logic       prev_start, prev_wdog, lat_pend;
   int         phase, rcnt;

   asrm_uart_tx_arbiter #(.N_REQ(4), .ID_W(2), .WDOG_MAX(50)) dut (
      .clk                 (clk),
      .reset               (reset),
      .req_valid           (req_valid),
      .req_data            (req_data),
      .req_ready           (req_ready),
      .uart_data_tx        (uart_data_tx),
      .uart_start_transmit (uart_start_transmit),
      .uart_end_transmit   (uart_end_transmit),
      .busy                (busy),
      .grant_id            (grant_id),
      .wdog_err            (wdog_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
   endtask

   task automatic fail_timeout(input string nm);
      n_chk++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask

   function automatic bit src_pending();
      for (int i = 0; i < 4; i++) if (src_q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   // Requester model: a byte stays valid until its req_ready pulse is seen.
   always begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] dummy;
         if (req_ready[i] && src_q[i].size() != 0) dummy = src_q[i].pop_front();
         req_valid[i]      = (src_q[i].size() != 0) || extra_v[i];
         req_data[8*i +: 8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
      end
   end

   // UART core stand-in: end_transmit rises 10 clk after start, stays high 3 clk.
   always @(negedge clk) begin
      if (!reset) begin
         phase = 0;
         rcnt = 0;
         uart_end_transmit = 1'b0;
      end else begin
         case (phase)
            0: if (uart_start_transmit && !hang) begin
               rcnt++;
               if (rcnt == 10) begin
                  uart_end_transmit = 1'b1;
                  phase = 1;
                  rcnt = 0;
               end
            end
            1: begin
               rcnt++;
               if (rcnt == 1) begin
                  check("start_drop", uart_start_transmit, 0);
                  check("busy_release", busy, 1);
               end
               if (rcnt == 3) begin
                  uart_end_transmit = 1'b0;
                  phase = 2;
               end
            end
            default: if (!uart_start_transmit) begin
               phase = 0;
               rcnt = 0;
            end
         endcase
      end
   end

   // Monitor: pops the scoreboard on every req_ready pulse.
   always @(negedge clk) begin
      exp_t e;
      if (lat_pend) begin
         check("start_latency", uart_start_transmit, 1);
         lat_pend = 1'b0;
      end
      if (uart_start_transmit && !prev_start) start_rises++;
      prev_start = uart_start_transmit;
      if (wdog_err && !prev_wdog) wdog_total++;
      prev_wdog = wdog_err;
      if (req_ready != 4'b0) begin
         check("ready_onehot", 32'($onehot(req_ready)), 1);
         if (req_ready[1]) ready1_cnt++;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_grant: req_ready=%b grant_id=%0d with nothing expected", req_ready, grant_id);
         end else begin
            e = exp_q.pop_front();
            check("grant_ready", req_ready, 4'b0001 << e.id);
            check("grant_id", grant_id, e.id);
            check("data_tx", uart_data_tx, e.data);
            check("busy_capture", busy, 1);
            lat_pend = 1'b1;
         end
      end
   end

   task automatic push(input int i, input logic [7:0] d);
      src_q[i].push_back(d);
   endtask

   task automatic expect_f(input logic [1:0] id, input logic [7:0] d);
      exp_t e;
      e.id = id;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_drain(input string nm);
      int k;
      k = 0;
      while (k < 3000 && (exp_q.size() != 0 || busy || src_pending())) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) fail_timeout(nm);
   endtask

   task automatic wait_start();
      int k;
      k = 0;
      while (k < 200 && !uart_start_transmit) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) fail_timeout("wait_start");
   endtask

   initial begin
      int run, r1;
      n_chk = 0; n_pass = 0;
      start_rises = 0; wdog_total = 0; ready1_cnt = 0;
      prev_start = 0; prev_wdog = 0; lat_pend = 0;
      extra_v = 4'b0; hang = 1'b0;
      req_valid = 4'b0; req_data = 32'h0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_data", uart_data_tx, 0);
      check("rst_start", uart_start_transmit, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant_id, 0);
      check("rst_wdog", wdog_err, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Single request
      push(0, 8'h55); expect_f(2'd0, 8'h55);
      wait_drain("single");

      // Contention from rr_ptr=0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(i, 8'hA0 + 8'(i));
         expect_f(2'(i), 8'hA0 + 8'(i));
      end
      wait_drain("contention");

      // Fairness: req0 busy stream, req2 interleaves
      do_reset();
      push(0, 8'h10); push(0, 8'h11); push(0, 8'h12); push(0, 8'h13);
      push(2, 8'h20); push(2, 8'h21);
      expect_f(2'd0, 8'h10); expect_f(2'd2, 8'h20); expect_f(2'd0, 8'h11);
      expect_f(2'd2, 8'h21); expect_f(2'd0, 8'h12); expect_f(2'd0, 8'h13);
      wait_drain("fairness");

      // Watchdog abort then recovery
      do_reset();
      hang = 1'b1;
      push(1, 8'h77); expect_f(2'd1, 8'h77);
      wait_start();
      run = 0;
      while (uart_start_transmit && run < 200) begin
         run++;
         @(negedge clk);
      end
      check("wdog_start_cycles", run, 50);
      check("wdog_err_pulse", wdog_err, 1);
      check("wdog_busy_hold", busy, 1);
      @(negedge clk);
      check("wdog_err_single", wdog_err, 0);
      check("wdog_busy_fall", busy, 0);
      hang = 1'b0;
      push(3, 8'h88); expect_f(2'd3, 8'h88);
      wait_drain("wdog_recover");

      // Asynchronous reset mid-frame, then rr_ptr must be back at 0
      do_reset();
      push(2, 8'h5A); expect_f(2'd2, 8'h5A);
      wait_start();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("mid_ready", req_ready, 0);
      check("mid_data", uart_data_tx, 0);
      check("mid_start", uart_start_transmit, 0);
      check("mid_busy", busy, 0);
      check("mid_grant", grant_id, 0);
      check("mid_wdog", wdog_err, 0);
      push(0, 8'hC0); push(3, 8'hC3);
      expect_f(2'd0, 8'hC0); expect_f(2'd3, 8'hC3);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wait_drain("post_reset");

      // Request withdrawn while another frame is busy
      do_reset();
      r1 = ready1_cnt;
      push(0, 8'hD0); expect_f(2'd0, 8'hD0);
      run = 0;
      while (!busy && run < 200) begin
         @(negedge clk);
         run++;
      end
      if (run >= 200) fail_timeout("withdraw_busy");
      @(negedge clk); extra_v = 4'b0010;
      @(negedge clk); extra_v = 4'b0000;
      wait_drain("withdraw");
      repeat (30) @(negedge clk);
      check("withdrawn_never_granted", ready1_cnt - r1, 0);

      check("frame_count", start_rises, 17);
      check("wdog_pulse_count", wdog_total, 1);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish at %0t", $time);
      $fatal(1, "global timeout");
   end

endmodule
